draw_line_fb: RTL
=================

Name: draw_line_fb

Overview:
- Bresenham line-drawing engine that sits directly upstream of the 160x120 1-bit framebuffer BRAM write port.
- Accepts a line request `(x0,y0)-(x1,y1)` in signed framebuffer coordinates and steps one pixel per enabled cycle.
- Emits registered write strobe, address and colour, so a top level connects them straight to the BRAM write port.
- Off-framebuffer pixels are stepped but never written, so lines are clipped to the framebuffer.

Parameters:
- CORDW, 16, signed coordinate width in bits.
- FB_WIDTH, 160, framebuffer width in pixels.
- FB_HEIGHT, 120, framebuffer height in pixels.
- FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer address width.
- FB_DATAW, 1, colour bits per pixel.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- oe  in  1  output enable; 0 stalls the engine.
- x0, y0, x1, y1  in  CORDW each, signed  line endpoints, sampled with start.
- colr  in  FB_DATAW  pixel colour, sampled with start.
- x, y  out  CORDW each, signed  current pixel, valid when drawing=1.
- drawing  out  1  x/y hold a new pixel this cycle.
- busy  out  1  line in progress (INIT or DRAW, including the write pipeline).
- done  out  1  one-cycle pulse when the line completes.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  FB_ADDRW  framebuffer write address.
- fb_colr  out  FB_DATAW  framebuffer write data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - x, y, drawing, busy, done, fb_we, fb_addr and fb_colr all go to 0.
  - All internal registers clear.
  - Reset mid-line aborts the line with no done pulse.
- States: IDLE -> INIT -> DRAW -> FLUSH -> IDLE.
- IDLE:
  - On start=1, latch endpoints and colr, set busy=1, go to INIT.
  - start in any other state is ignored.
- INIT, one cycle, unconditional:
  - dx = |x1-x0|, dy = -|y1-y0|, both CORDW+1 signed.
  - err = dx+dy, CORDW+2 signed.
  - Step sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1.
  - Load cur = (x0,y0), then go to DRAW.
- DRAW, each cycle with oe=1:
  - Present cur on x/y with drawing=1.
  - If cur == (x1,y1), go to FLUSH. Otherwise advance with e2 = 2*err, CORDW+3 signed:
    - if e2 >= dy: x += sx and err gets +dy.
    - if e2 <= dx: y += sy and err gets +dx.
    - Both conditions may hold in the same cycle; err then updates once with the sum.
- oe=0 in DRAW: state, cur and err hold; drawing=0 for that cycle.
- Timing: start sampled at edge E0, INIT at E1, first drawing=1 after E2. Pixel count per line is max(|dx|,|dy|)+1.
- Write stage, one register stage after drawing:
  - fb_we = drawing && 0<=x<FB_WIDTH && 0<=y<FB_HEIGHT.
  - fb_addr = y*FB_WIDTH + x, truncated to FB_ADDRW; it is only meaningful when fb_we=1.
  - fb_colr = latched colr.
- FLUSH, one cycle:
  - The final pixel's fb_we (or suppressed write) is presented.
  - done=1 for exactly that cycle; busy falls to 0 on the same edge that done rises.
  - Next state is IDLE.
  - A start in the cycle after done is accepted.
- Degenerate point line (x0==x1, y0==y1): exactly one pixel, then done.
- Fully off-screen line: steps normally, fb_we stays 0 throughout, done still pulses.

Test Plan:
- Horizontal line: start with (0,60)-(159,60), colr=1, oe=1. Expect 160 consecutive fb_we with fb_addr 9600..9759, first fb_we 3 cycles after start, done coincident with the addr 9759 write, busy low after.
- Diagonal: (0,0)-(3,3). Expect pixels (0,0),(1,1),(2,2),(3,3) and addresses 0,161,322,483.
- Steep reverse line: (5,10)-(3,4). Expect 7 pixels, y stepping 10 down to 4 exactly once per pixel, x monotonically 5 to 3, endpoints exact.
- Clipping: (-2,0)-(2,0). Expect 5 drawing cycles but fb_we only for x=0,1,2 at addresses 0,1,2; a point line at (200,5) gives no fb_we and one done.
- Stall: (0,0)-(4,0) with oe toggling 1,0,1,0,... Expect no pixel skipped or repeated, drawing=0 on stall cycles, 5 writes total; a start asserted while busy is ignored.
- Async reset: assert rst_n=0 mid-line (after 3 pixels), not aligned to clk. Expect every output 0 immediately, no done pulse, and a new start after release draws correctly from IDLE.

Source files
------------

// File: rtl/draw_line_fb.sv
// Bresenham line engine feeding a 1-bit framebuffer write port.
// Steps one pixel per enabled cycle and clips writes to the framebuffer bounds.
module draw_line_fb #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT),
    parameter int FB_DATAW  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       oe,
    input  logic signed [CORDW-1:0]    x0,
    input  logic signed [CORDW-1:0]    y0,
    input  logic signed [CORDW-1:0]    x1,
    input  logic signed [CORDW-1:0]    y1,
    input  logic        [FB_DATAW-1:0] colr,
    output logic signed [CORDW-1:0]    x,
    output logic signed [CORDW-1:0]    y,
    output logic                       drawing,
    output logic                       busy,
    output logic                       done,
    output logic                       fb_we,
    output logic        [FB_ADDRW-1:0] fb_addr,
    output logic        [FB_DATAW-1:0] fb_colr
);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, FLUSH} state_t;

    localparam logic signed [CORDW-1:0] FBW_S = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] FBH_S = CORDW'(FB_HEIGHT);
    localparam logic [FB_ADDRW-1:0]     FBW_A = FB_ADDRW'(FB_WIDTH);

    state_t                     state_q;
    logic signed [CORDW-1:0]    x0_q, y0_q, x1_q, y1_q;
    logic signed [CORDW-1:0]    cx_q, cy_q, cx_d, cy_d;
    logic signed [CORDW-1:0]    x_q, y_q;
    logic signed [CORDW:0]      dx_q, dy_q;
    logic signed [CORDW+1:0]    err_q, err_d;
    logic                       sx_q, sy_q;
    logic [FB_DATAW-1:0]        colr_q, fb_colr_q;
    logic                       drawing_q, busy_q, done_q, fb_we_q;
    logic [FB_ADDRW-1:0]        fb_addr_q, fb_addr_d;

    logic signed [CORDW:0]      ddx, ddy, adx, ady;
    logic signed [CORDW+1:0]    err_init, add_x, add_y;
    logic signed [CORDW+2:0]    e2, dx_e, dy_e;
    logic                       step_x, step_y, at_end, in_fb;

    // Setup arithmetic, evaluated from the latched endpoints during INIT
    always_comb begin
        ddx      = $signed({x1_q[CORDW-1], x1_q}) - $signed({x0_q[CORDW-1], x0_q});
        ddy      = $signed({y1_q[CORDW-1], y1_q}) - $signed({y0_q[CORDW-1], y0_q});
        adx      = ddx[CORDW] ? -ddx : ddx;
        ady      = ddy[CORDW] ? -ddy : ddy;
        err_init = $signed({adx[CORDW], adx}) - $signed({ady[CORDW], ady});
    end

    // One Bresenham step; both axes may move, err absorbs the sum
    always_comb begin
        e2     = $signed({err_q, 1'b0});
        dx_e   = $signed({{2{dx_q[CORDW]}}, dx_q});
        dy_e   = $signed({{2{dy_q[CORDW]}}, dy_q});
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        add_x  = '0;
        add_y  = '0;
        if (step_x) add_x = $signed({dy_q[CORDW], dy_q});
        if (step_y) add_y = $signed({dx_q[CORDW], dx_q});
        err_d  = err_q + add_x + add_y;
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (step_x) cx_d = sx_q ? cx_q + CORDW'(1) : cx_q - CORDW'(1);
        if (step_y) cy_d = sy_q ? cy_q + CORDW'(1) : cy_q - CORDW'(1);
        at_end = (cx_q == x1_q) && (cy_q == y1_q);
    end

    always_comb begin
        in_fb     = !x_q[CORDW-1] && (x_q < FBW_S) && !y_q[CORDW-1] && (y_q < FBH_S);
        fb_addr_d = y_q[FB_ADDRW-1:0] * FBW_A + x_q[FB_ADDRW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            colr_q    <= '0;
            fb_colr_q <= '0;
            drawing_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
        end else begin
            done_q    <= 1'b0;
            drawing_q <= 1'b0;
            // Write stage trails the pixel stage by one register
            fb_we_q   <= drawing_q && in_fb;
            fb_addr_q <= fb_addr_d;
            fb_colr_q <= colr_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x0_q    <= x0;
                        y0_q    <= y0;
                        x1_q    <= x1;
                        y1_q    <= y1;
                        colr_q  <= colr;
                        busy_q  <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    dx_q    <= adx;
                    dy_q    <= -ady;
                    err_q   <= err_init;
                    sx_q    <= (x0_q < x1_q);
                    sy_q    <= (y0_q < y1_q);
                    cx_q    <= x0_q;
                    cy_q    <= y0_q;
                    state_q <= DRAW;
                end
                DRAW: begin
                    if (oe) begin
                        drawing_q <= 1'b1;
                        x_q       <= cx_q;
                        y_q       <= cy_q;
                        if (at_end) begin
                            state_q <= FLUSH;
                        end else begin
                            cx_q  <= cx_d;
                            cy_q  <= cy_d;
                            err_q <= err_d;
                        end
                    end
                end
                FLUSH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign drawing = drawing_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_colr = fb_colr_q;

endmodule
